// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Issues word requests to instruction memory, tracks the fetch PC, and
// delivers instruction/next-PC pairs across the IF/ID boundary. It honours
// decode stalls and jump/branch redirects. In-flight responses are
// discarded on redirect, and one response is buffered while decode stalls.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   imem_req/addr      request to instruction memory (held until imem_ack)
//   imem_ack/rdata     memory response
//   stall              decode cannot accept; IF/ID outputs hold
//   redirect/_pc       taken jump/branch; flush and refetch from redirect_pc
//   instruction        registered instruction (NOP_INSTR when not valid)
//   out_next_pc        registered address of instruction + PC_STEP
//   instr_valid        instruction/out_next_pc hold a real instruction
// Optional (macro IF_PERF_COUNT_EN):
//   perf_fetched       count of instructions delivered to decode
//   perf_stall_cycles  count of cycles with stall=1 and instr_valid=1
module fetch_unit #(
  parameter int unsigned          PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
  parameter int unsigned          PC_STEP   = 1,
  parameter logic [31:0]          NOP_INSTR = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [31:0]         instruction,
  output logic [PC_WIDTH-1:0] out_next_pc,
  output logic                instr_valid
`ifdef IF_PERF_COUNT_EN
  ,
  output logic [31:0]         perf_fetched,
  output logic [31:0]         perf_stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;

  localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(PC_STEP);

  state_t              state;
  logic [PC_WIDTH-1:0] fetch_addr;
  logic [PC_WIDTH-1:0] pend_pc;
  logic [PC_WIDTH-1:0] hold_npc;
  logic [31:0]         hold_instr;
  logic [PC_WIDTH-1:0] seq_pc;

  // Wraps modulo 2^PC_WIDTH.
  assign seq_pc    = fetch_addr + STEP;
  assign imem_addr = fetch_addr;
  // Decoded straight from the state register, so it is glitch-free.
  assign imem_req  = (state == FETCH) || (state == DISCARD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fetch_addr  <= RESET_PC;
      pend_pc     <= '0;
      hold_instr  <= '0;
      hold_npc    <= '0;
      instruction <= NOP_INSTR;
      out_next_pc <= '0;
      instr_valid <= 1'b0;
    end else begin
      // Redirect flushes the IF/ID outputs in every state, overriding stall.
      if (redirect) begin
        instruction <= NOP_INSTR;
        instr_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (redirect) fetch_addr <= redirect_pc;
          state <= FETCH;
        end
        FETCH: begin
          if (redirect) begin
            if (imem_ack) begin
              fetch_addr <= redirect_pc;
            end else begin
              // Request still outstanding: it must complete before refetching.
              pend_pc <= redirect_pc;
              state   <= DISCARD;
            end
          end else if (stall) begin
            if (imem_ack) begin
              hold_instr <= imem_rdata;
              hold_npc   <= seq_pc;
              fetch_addr <= seq_pc;
              state      <= HOLD;
            end
          end else if (imem_ack) begin
            instruction <= imem_rdata;
            out_next_pc <= seq_pc;
            instr_valid <= 1'b1;
            fetch_addr  <= seq_pc;
          end else begin
            instruction <= NOP_INSTR;
            instr_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (redirect) begin
            fetch_addr <= redirect_pc;
            state      <= FETCH;
          end else if (!stall) begin
            instruction <= hold_instr;
            out_next_pc <= hold_npc;
            instr_valid <= 1'b1;
            state       <= FETCH;
          end
        end
        DISCARD: begin
          if (redirect) begin
            pend_pc <= redirect_pc;
            if (imem_ack) begin
              fetch_addr <= redirect_pc;
              state      <= FETCH;
            end
          end else if (imem_ack) begin
            fetch_addr <= pend_pc;
            state      <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IF_PERF_COUNT_EN
  logic deliver;

  assign deliver = !redirect && !stall &&
                   (((state == FETCH) && imem_ack) || (state == HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_fetched      <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (deliver)               perf_fetched      <= perf_fetched + 32'd1;
      if (stall && instr_valid)  perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int BUB = 0;  // expect bubble: valid=0, instruction=NOP
  localparam int NEW = 1;  // expect next scoreboard entry
  localparam int HLD = 2;  // expect outputs unchanged

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instruction;
  logic [31:0] out_next_pc;
  logic        instr_valid;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  logic [31:0] exp_addr;
  logic [31:0] q_instr[$];
  logic [31:0] q_npc[$];
  logic [31:0] last_instr;
  logic [31:0] last_npc;

  fetch_unit #(
    .PC_WIDTH (32),
    .RESET_PC (32'h0),
    .PC_STEP  (1),
    .NOP_INSTR(32'h0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instruction(instruction),
    .out_next_pc(out_next_pc),
    .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock step: check request side at negedge, drive inputs, then
  // check the IF/ID outputs 1 time unit after the rising edge.
  task automatic cyc(input bit exp_req, input bit ack, input bit stl, input bit rd,
                     input logic [31:0] rpc, input bit push_it, input int out_kind);
    @(negedge clk);
    chk("imem_req", {31'b0, imem_req}, {31'b0, exp_req});
    if (exp_req) chk("imem_addr", imem_addr, exp_addr);
    imem_ack    = ack;
    imem_rdata  = exp_addr * 32'd3;
    stall       = stl;
    redirect    = rd;
    redirect_pc = rpc;
    if (push_it) begin
      q_instr.push_back(exp_addr * 32'd3);
      q_npc.push_back(exp_addr + 32'd1);
    end
    @(posedge clk);
    #1;
    case (out_kind)
      BUB: begin
        chk("bubble_valid", {31'b0, instr_valid}, 32'd0);
        chk("bubble_instr", instruction, 32'h0);
      end
      NEW: begin
        n_assert++;
        assert (q_instr.size() > 0) else begin
          n_fail++;
          $error("FAIL sb_empty observed=%0d expected=%0d", q_instr.size(), 1);
        end
        if (q_instr.size() > 0) begin
          last_instr = q_instr.pop_front();
          last_npc   = q_npc.pop_front();
        end
        chk("new_valid", {31'b0, instr_valid}, 32'd1);
        chk("new_instr", instruction, last_instr);
        chk("new_npc", out_next_pc, last_npc);
      end
      default: begin
        chk("hold_valid", {31'b0, instr_valid}, 32'd1);
        chk("hold_instr", instruction, last_instr);
        chk("hold_npc", out_next_pc, last_npc);
      end
    endcase
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = '0; exp_addr = '0;
    last_instr = '0; last_npc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instruction, 32'h0);
    chk("rst_npc", out_next_pc, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_addr", imem_addr, 32'h0);
    rst = 1'b0;

    // IDLE cycle, no request yet
    cyc(0, 0, 0, 0, 0, 0, BUB);

    // Zero-wait memory: one instruction per cycle, addresses 0..4
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, 0, 0, 0, 1, NEW);
      exp_addr = exp_addr + 32'd1;
    end

    // Stall while addr 5 acks: outputs frozen on addr 4, then released
    cyc(1, 1, 1, 0, 0, 1, HLD);
    exp_addr = 32'd6;
    cyc(0, 0, 1, 0, 0, 0, HLD);
    cyc(0, 0, 0, 0, 0, 0, NEW);

    // Ack delayed 3 cycles for addr 6
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0, BUB);
    cyc(1, 1, 0, 0, 0, 1, NEW);
    exp_addr = 32'd7;

    // Redirect to 0x40 while addr 7 outstanding; ack arrives 2 cycles later
    cyc(1, 0, 0, 1, 32'h40, 0, BUB);
    cyc(1, 0, 0, 0, 0, 0, BUB);
    cyc(1, 1, 0, 0, 0, 0, BUB);
    exp_addr = 32'h40;
    cyc(1, 1, 0, 0, 0, 1, NEW);
    exp_addr = 32'h41;

    // Two redirects during DISCARD: latest (0x80) wins
    cyc(1, 0, 0, 1, 32'h40, 0, BUB);
    cyc(1, 0, 0, 1, 32'h80, 0, BUB);
    cyc(1, 1, 0, 0, 0, 0, BUB);
    exp_addr = 32'h80;
    cyc(1, 1, 0, 0, 0, 1, NEW);
    exp_addr = 32'h81;

    // Redirect with simultaneous stall flushes valid output
    cyc(1, 0, 1, 1, 32'h90, 0, BUB);
    cyc(1, 1, 0, 0, 0, 0, BUB);
    exp_addr = 32'h90;

    // Redirect in DISCARD on the same cycle as ack
    cyc(1, 0, 0, 1, 32'hA0, 0, BUB);
    cyc(1, 1, 0, 1, 32'hB0, 0, BUB);
    exp_addr = 32'hB0;
    cyc(1, 1, 0, 0, 0, 1, NEW);
    exp_addr = 32'hB1;

    // Redirect in HOLD drops the buffered response
    cyc(1, 1, 1, 0, 0, 0, HLD);
    cyc(0, 0, 1, 1, 32'hC0, 0, BUB);
    exp_addr = 32'hC0;

    // Redirect with ack in FETCH, then PC wrap at all-ones
    cyc(1, 1, 0, 1, 32'hFFFF_FFFF, 0, BUB);
    exp_addr = 32'hFFFF_FFFF;
    cyc(1, 1, 0, 0, 0, 1, NEW);
    exp_addr = 32'h0;
    cyc(1, 1, 0, 0, 0, 1, NEW);
    exp_addr = 32'h1;

    // Reset asserted mid-request drops the request
    @(negedge clk);
    rst = 1'b1; imem_ack = 1'b0; stall = 1'b0; redirect = 1'b0;
    @(posedge clk);
    #1;
    chk("rst2_req", {31'b0, imem_req}, 32'd0);
    chk("rst2_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst2_addr", imem_addr, 32'h0);
    chk("sb_drained", q_instr.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
